// File: rtl/shift_reg_pkg.sv
// Shared constants for the parameterised shift register:
// mode codes, FSM states and a multi-step mode qualifier.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic is_multi(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_step_unit.sv
// One step of the shift register: next Q from mode,
// current Q and the two serial inputs.
module shift_step_unit
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             si_l,
  input  logic             si_r,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    unique case (1'b1)
      (mode == MODE_LOAD): q_next = d;
      (mode == MODE_SHL):  q_next = {q[WIDTH-2:0], si_l};
      (mode == MODE_SHR):  q_next = {si_r, q[WIDTH-1:1]};
      (mode == MODE_ROL):  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      (mode == MODE_ROR):  q_next = {q[0], q[WIDTH-1:1]};
      (mode == MODE_ASR):  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default:             q_next = q;
    endcase
  end

endmodule

// File: rtl/param_shift_register.sv
// Universal shift register with single-step modes and a
// counted multi-step run (FSM, counter, done pulse).
module param_shift_register
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       M,
  input  logic [WIDTH-1:0] D,
  input  logic             SI_L,
  input  logic             SI_R,
  input  logic [CNT_W-1:0] AMT,
  input  logic             start,
  output logic [WIDTH-1:0] Q,
  output logic             SO_L,
  output logic             SO_R,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] WMAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       mode_q, mode_n;
  logic [WIDTH-1:0] q_n, step_q;
  logic             done_n;
  logic [2:0]       step_mode;
  logic [CNT_W-1:0] k;

  assign k = (AMT > WMAX) ? WMAX : AMT;
  assign step_mode = (st == RUN) ? mode_q : M;

  shift_step_unit #(.WIDTH(WIDTH)) u_step (
    .mode   (step_mode),
    .q      (Q),
    .d      (D),
    .si_l   (SI_L),
    .si_r   (SI_R),
    .q_next (step_q)
  );

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    mode_n = mode_q;
    q_n    = Q;
    done_n = 1'b0;
    unique case (st)
      IDLE: begin
        if (start && is_multi(M)) begin
          // Request edge only captures; Q moves from the next edge.
          mode_n = M;
          if (k != '0) begin
            st_n  = RUN;
            cnt_n = k;
          end else begin
            done_n = 1'b1;
          end
        end else begin
          q_n = step_q;
        end
      end
      RUN: begin
        q_n   = step_q;
        cnt_n = cnt - ONE;
        if (cnt == ONE) begin
          st_n   = IDLE;
          done_n = 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= IDLE;
      cnt    <= '0;
      mode_q <= MODE_HOLD;
      Q      <= '0;
      done   <= 1'b0;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      mode_q <= mode_n;
      Q      <= q_n;
      done   <= done_n;
    end
  end

  assign busy = (st == RUN);
  assign SO_L = Q[WIDTH-1];
  assign SO_R = Q[0];

endmodule
